// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: assembles a SYNC-framed 8-word command block from a byte stream and strobes RCV.
// Define CMD_FRAME_RX_CHECKSUM_EN to append and verify a trailing XOR checksum byte.
module cmd_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd5000,
    parameter int          RCV_LEN   = 8,
    parameter int          RCV_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] CMND,
    output logic [31:0] TNO,
    output logic [31:0] TNC,
    output logic [31:0] TOBM,
    output logic [31:0] TNI,
    output logic [31:0] TKI,
    output logic [31:0] TNP,
    output logic [31:0] TKP,
    output logic        RCV,
    output logic        frame_err,
    output logic        overrun
);

    localparam int CMAX = (RCV_LEN > RCV_GAP) ? RCV_LEN : RCV_GAP;
    localparam int CW   = $clog2(CMAX + 1);

`ifdef CMD_FRAME_RX_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CSUM} rx_state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD} rx_state_t;
`endif
    typedef enum logic [1:0] {R_QUIET, R_HIGH, R_GAP} rcv_state_t;

    rx_state_t         state;
    logic [4:0]        byte_cnt;
    logic [15:0]       idle_cnt;
    logic [7:0][31:0]  shadow;
    logic              acc;
`ifdef CMD_FRAME_RX_CHECKSUM_EN
    logic [7:0]        csum;
    logic              csum_bad;
`endif

    rcv_state_t        rstate;
    logic [CW-1:0]     rcv_cnt;
    logic [7:0][31:0]  pend;
    logic              pend_vld;
    logic [7:0][31:0]  words;
    logic              free;

    // Receive FSM: acc / csum_bad are staged one clock so the outputs react at N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            shadow    <= '1;
            acc       <= 1'b0;
            frame_err <= 1'b0;
`ifdef CMD_FRAME_RX_CHECKSUM_EN
            csum      <= '0;
            csum_bad  <= 1'b0;
`endif
        end else begin
            acc <= 1'b0;
`ifdef CMD_FRAME_RX_CHECKSUM_EN
            csum_bad  <= 1'b0;
            frame_err <= csum_bad;
`else
            frame_err <= 1'b0;
`endif
            if (state != S_IDLE && !rx_valid) begin
                if (idle_cnt == TIMEOUT) begin
                    state     <= S_IDLE;
                    idle_cnt  <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
            end
            if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state    <= S_PAYLOAD;
                            byte_cnt <= '0;
                            idle_cnt <= '0;
`ifdef CMD_FRAME_RX_CHECKSUM_EN
                            csum     <= '0;
`endif
                        end
                    end
                    S_PAYLOAD: begin
                        shadow[byte_cnt[4:2]] <= {shadow[byte_cnt[4:2]][23:0], rx_data};
                        byte_cnt <= byte_cnt + 5'd1;
                        idle_cnt <= '0;
`ifdef CMD_FRAME_RX_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
                        if (byte_cnt == 5'd31) state <= S_CSUM;
`else
                        if (byte_cnt == 5'd31) begin
                            state <= S_IDLE;
                            acc   <= 1'b1;
                        end
`endif
                    end
`ifdef CMD_FRAME_RX_CHECKSUM_EN
                    S_CSUM: begin
                        state    <= S_IDLE;
                        idle_cnt <= '0;
                        if (rx_data == csum) acc <= 1'b1;
                        else                 csum_bad <= 1'b1;
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The engine can take a frame when quiet or on the last GAP clock.
    assign free = (rstate == R_QUIET) || (rstate == R_GAP && rcv_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate   <= R_QUIET;
            rcv_cnt  <= '0;
            RCV      <= 1'b0;
            overrun  <= 1'b0;
            pend     <= '1;
            pend_vld <= 1'b0;
            words    <= '1;
        end else begin
            overrun <= 1'b0;
            if (free && (acc || pend_vld)) begin
                // Older pending frame goes out first; a simultaneous accept takes its place.
                words    <= pend_vld ? pend : shadow;
                RCV      <= 1'b1;
                rstate   <= R_HIGH;
                rcv_cnt  <= CW'(RCV_LEN - 1);
                if (acc && pend_vld) pend <= shadow;
                pend_vld <= acc && pend_vld;
            end else begin
                if (acc) begin
                    pend     <= shadow;
                    pend_vld <= 1'b1;
                    overrun  <= pend_vld;
                end
                case (rstate)
                    R_HIGH: begin
                        if (rcv_cnt == '0) begin
                            RCV     <= 1'b0;
                            rstate  <= R_GAP;
                            rcv_cnt <= CW'(RCV_GAP - 1);
                        end else begin
                            rcv_cnt <= rcv_cnt - 1'b1;
                        end
                    end
                    R_GAP: begin
                        if (rcv_cnt == '0) rstate <= R_QUIET;
                        else               rcv_cnt <= rcv_cnt - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign CMND = words[0];
    assign TNO  = words[1];
    assign TNC  = words[2];
    assign TOBM = words[3];
    assign TNI  = words[4];
    assign TKI  = words[5];
    assign TNP  = words[6];
    assign TKP  = words[7];

endmodule
